// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: FSM state encoding, queue entry layout and
// the instruction width in bytes used to advance the program counter.
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam int unsigned INSTR_BYTES = 4;

  // Sequential PC step; wraps naturally from 32'hFFFF_FFFC to 0.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: small synchronous FIFO of fetch_entry_t with flush.
// Pop on an empty queue is ignored; push into a full queue without a
// simultaneous pop must never happen and is asserted against.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            pop_eff;
  logic            push_eff;

  assign pop_eff  = pop && (count != '0) && !flush;
  assign push_eff = push && !flush;
  assign head     = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_eff) - CW'(pop_eff);
    end
  end

  // Entry storage; contents are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= push_data;
  end

  overflow_check: assert property (@(posedge clk) disable iff (rst)
    !(push_eff && !pop_eff && (count == CW'(DEPTH))));

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, issues single-outstanding word
// requests, tags responses with their PC and queues them for decode.
// Optional feature: MISALIGN_CHECK_EN halts on a misaligned redirect target;
// without it the low two target bits are cleared on load.
// Handshake: a head entry transfers on a cycle where out_valid && out_ready;
// a request transfers where imem_req && imem_gnt.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          QUEUE_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction_memory,
  output logic [31:0] program_counter,
  output logic        fetch_misaligned,
  output logic [1:0]  fsm_state
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [1:0] S_FETCH = 2'(FETCH);
  localparam logic [1:0] S_DRAIN = 2'(DRAIN);
`ifdef MISALIGN_CHECK_EN
  localparam logic [1:0] S_HALT  = 2'(HALT);
`endif

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [31:0]   tag_pc;
  logic          outstanding;
  logic          run;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          grant;
  logic          resp;
  logic          push;
  logic [31:0]   target;
  logic          keep_drain;

  assign grant      = imem_req && imem_gnt;
  // A response only counts against a live request; pre-reset returns are dropped.
  assign resp       = imem_rvalid && outstanding;
  assign push       = resp && (state == S_FETCH) && !redirect_valid;
  assign push_data  = '{instr: imem_rdata, pc: tag_pc};
  // A stale word is still in flight after the redirect if granted now or not yet returned.
  assign keep_drain = grant || (outstanding && !imem_rvalid);

`ifdef MISALIGN_CHECK_EN
  logic misaligned;
  assign target           = redirect_pc;
  assign fetch_misaligned = misaligned;
`else
  assign target           = redirect_pc & ~32'h3;
  assign fetch_misaligned = 1'b0;
`endif

  // Request whenever fetching with room for the returning word.
  assign imem_req  = run && (state == S_FETCH) && !outstanding &&
                     ((32'(count) + 32'(outstanding)) < 32'(QUEUE_DEPTH));
  assign imem_addr = pc;

  assign out_valid          = (count != '0);
  assign instruction_memory = out_valid ? head.instr : 32'h0;
  assign program_counter    = out_valid ? head.pc    : 32'h0;
  assign fsm_state          = state;

  // PC, outstanding/tag tracking and FSM; redirect has top priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_VECTOR;
      tag_pc      <= 32'h0;
      outstanding <= 1'b0;
      run         <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misaligned  <= 1'b0;
`endif
    end else begin
      run <= 1'b1;
      if (grant) begin
        outstanding <= 1'b1;
        tag_pc      <= pc;
      end else if (resp) begin
        outstanding <= 1'b0;
      end
      if (redirect_valid) begin
        pc <= target;
`ifdef MISALIGN_CHECK_EN
        if (target[1:0] != 2'b00) begin
          state      <= S_HALT;
          misaligned <= 1'b1;
        end else begin
          misaligned <= 1'b0;
          state      <= keep_drain ? S_DRAIN : S_FETCH;
        end
`else
        state <= keep_drain ? S_DRAIN : S_FETCH;
`endif
      end else begin
        if (grant) pc <= next_pc(pc);
        if ((state == S_DRAIN) && resp) state <= S_FETCH;
      end
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory model with programmable grant and
// latency, directed expected-word tables pushed into a scoreboard queue and
// a monitor that pops and compares on every accepted output.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction_memory;
  logic [31:0] program_counter;
  logic        fetch_misaligned;
  logic [1:0]  fsm_state;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  // memory model controls/state
  logic        gnt_en = 1'b1;
  int          lat = 1;
  int          grant_cnt = 0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] paddr = 32'h0;

  // monitor controls
  int  cyc = 0;
  logic check_gap = 1'b0;
  int  last_pop = -1;

  instruction_fetch_unit dut (
    .clk                (clk),
    .rst                (rst),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_gnt           (imem_gnt),
    .imem_rvalid        (imem_rvalid),
    .imem_rdata         (imem_rdata),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .instruction_memory (instruction_memory),
    .program_counter    (program_counter),
    .fetch_misaligned   (fetch_misaligned),
    .fsm_state          (fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  // memory model: word = addr ^ 32'hDEAD_0000, rvalid lat cycles after grant
  initial begin
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (pend && pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = paddr ^ 32'hDEAD_0000;
        pend = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        if (pend) pend_cnt--;
      end
      imem_gnt = gnt_en;
      if (imem_req && imem_gnt) begin
        pend = 1'b1;
        paddr = imem_addr;
        pend_cnt = lat - 1;
        grant_cnt++;
      end
    end
  end

  // monitor: pop expected entry on every accepted output
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out act=%h/%h req=none", instruction_memory, program_counter);
        end else begin
          e = exp_q.pop_front();
          if ({instruction_memory, program_counter} !== e) begin
            failures++;
            $display("FAIL out_word act=%h/%h req=%h/%h", instruction_memory, program_counter,
                     e[63:32], e[31:0]);
          end
        end
        if (check_gap) begin
          if (last_pop >= 0) begin
            checks++;
            if (cyc - last_pop > 2) begin
              failures++;
              $display("FAIL pop_gap act=%0d req<=2", cyc - last_pop);
            end
          end
          last_pop = cyc;
        end
      end
    end
  end

  // driver tasks
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  task automatic redirect(input logic [31:0] a);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = a;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    @(negedge clk);
    out_ready = 1'b1;
    for (t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
    out_ready = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain act=%0d_left req=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] t1 [4] = '{{32'hDEAD0000, 32'h0}, {32'hDEAD0004, 32'h4},
                            {32'hDEAD0008, 32'h8}, {32'hDEAD000C, 32'hC}};
    logic [63:0] t3 [3] = '{{32'hDEAD0100, 32'h100}, {32'hDEAD0104, 32'h104},
                            {32'hDEAD0108, 32'h108}};
    logic [63:0] t4 [2] = '{{32'hDEAD0300, 32'h300}, {32'hDEAD0304, 32'h304}};
    logic [63:0] t5 [3] = '{{32'h2152FFFC, 32'hFFFFFFFC}, {32'hDEAD0000, 32'h0},
                            {32'hDEAD0004, 32'h4}};
`ifdef MISALIGN_CHECK_EN
    logic [63:0] t6 [2] = '{{32'hDEAD0200, 32'h200}, {32'hDEAD0204, 32'h204}};
`else
    logic [63:0] t6 [2] = '{{32'hDEAD0100, 32'h100}, {32'hDEAD0104, 32'h104}};
`endif
    bit hit;

    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check32("rst_imem_req", 32'(imem_req), 32'h0);
    check32("rst_out_valid", 32'(out_valid), 32'h0);
    check32("rst_instr", instruction_memory, 32'h0);
    check32("rst_pc", program_counter, 32'h0);
    check32("rst_misaligned", 32'(fetch_misaligned), 32'h0);
    check32("rst_state", 32'(fsm_state), 32'h0);

    // 1: sequential fetch from reset, 1-cycle memory, consumer always ready
    for (int i = 0; i < 4; i++) exp_q.push_back(t1[i]);
    check_gap = 1'b1;
    last_pop = -1;
    @(negedge clk);
    out_ready = 1'b1;
    rst = 1'b0;
    drain("seq");
    check_gap = 1'b0;

    // 2: backpressure fills exactly QUEUE_DEPTH then stops requesting
    do_reset();
    grant_cnt = 0;
    repeat (10) @(negedge clk);
    #1;
    check32("bp_grants", 32'(grant_cnt), 32'd2);
    check32("bp_imem_req", 32'(imem_req), 32'h0);
    check32("bp_head_pc", program_counter, 32'h0);
    check32("bp_head_instr", instruction_memory, 32'hDEAD0000);
    repeat (3) @(negedge clk);
    #1;
    check32("bp_head_pc_hold", program_counter, 32'h0);
    check32("bp_head_instr_hold", instruction_memory, 32'hDEAD0000);
    for (int i = 0; i < 4; i++) exp_q.push_back(t1[i]);
    drain("bp");

    // 3: redirect while a request is outstanding discards the stale word
    lat = 3;
    redirect(32'h40);
    hit = 1'b0;
    for (int t = 0; t < 50 && !hit; t++) begin
      @(negedge clk);
      #2;
      if (imem_req && imem_gnt) hit = 1'b1;
    end
    check32("rd_grant_seen", 32'(hit), 32'h1);
    redirect(32'h100);
    for (int i = 0; i < 3; i++) exp_q.push_back(t3[i]);
    drain("redirect");

    // 4: grant stall keeps the address stable, then slow response
    gnt_en = 1'b0;
    redirect(32'h300);
    hit = 1'b0;
    for (int t = 0; t < 20 && !hit; t++) begin
      #1;
      if (imem_req) hit = 1'b1;
      else @(negedge clk);
    end
    check32("stall_req_seen", 32'(hit), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check32("stall_addr", imem_addr, 32'h300);
    end
    gnt_en = 1'b1;
    for (int i = 0; i < 2; i++) exp_q.push_back(t4[i]);
    drain("stall");

    // 5: PC wraps from the top of the address space
    lat = 1;
    redirect(32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) exp_q.push_back(t5[i]);
    drain("wrap");

    // 6: misaligned redirect target
    redirect(32'h0000_0102);
`ifdef MISALIGN_CHECK_EN
    repeat (3) @(negedge clk);
    #1;
    check32("mis_flag", 32'(fetch_misaligned), 32'h1);
    check32("mis_imem_req", 32'(imem_req), 32'h0);
    check32("mis_out_valid", 32'(out_valid), 32'h0);
    redirect(32'h200);
    #1;
    check32("mis_flag_clear", 32'(fetch_misaligned), 32'h0);
`else
    #1;
    check32("mis_flag_tied", 32'(fetch_misaligned), 32'h0);
`endif
    for (int i = 0; i < 2; i++) exp_q.push_back(t6[i]);
    drain("misalign");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
